sig_filter: RTL and testbench
=============================

// Module: sig_filter
// PURPOSE
//  - Majority-free glitch filter / debouncer for one serial 1-bit input line.
//  - Samples sig_in every clock into a DEPTH-stage history register.
//  - sig_out rises only after DEPTH consecutive 1 samples and falls only after DEPTH consecutive 0 samples.
//  - Any mixed history holds the previous sig_out.
//  - Sits between an asynchronous or noisy serial source and downstream synchronous logic.
// PARAMETERS
//  - DEPTH  3  consecutive identical samples required to change sig_out; legal range 2..16.
// PORTS
//  - clock    in   1  single clock; all state updates on the rising edge.
//  - reset    in   1  synchronous, active-low reset, sampled on the rising clock edge.
//  - sig_in   in   1  raw input; sampled each rising edge (caller synchronises if asynchronous).
//  - sig_out  out  1  filtered output, registered.
//  - edge_out out  1  present only with SIG_FILTER_EDGE_EN; see CONFIGURATION.
// BEHAVIOUR
//  - Reset: when reset==0 at a rising edge, clear the history register hist[DEPTH-1:0] to 0.
//    Also clear sig_out (and edge_out) to 0. sig_in is ignored on that edge.
//  - Normal edge (reset==1), all decisions use hist as it was before the edge:
//    - &hist==1  -> sig_out<=1
//    - |hist==0  -> sig_out<=0
//    - otherwise -> sig_out holds.
//  - On the same edge, hist <= {hist[DEPTH-2:0], sig_in}, i.e. a new sample is shifted in at bit 0.
//  - Latency: let sig_in be stable at value v and first sampled at edge n.
//    - hist is all-v after edge n+DEPTH-1.
//    - sig_out==v is visible after edge n+DEPTH, i.e. DEPTH+1 edges counting edge n.
//    - If sig_out already equals v, there is no change.
//  - Pulses shorter than DEPTH clocks are never passed through, whether high-going or low-going.
//  - Alternating 1/0 input holds sig_out indefinitely.
//  - After reset: sig_out is 0, and the history is already all-0.
//    - A steady 0 input keeps sig_out at 0.
//    - A steady 1 input needs DEPTH samples plus one edge to assert.
//  - Reset mid-operation aborts any partial history immediately, on that same edge.
//  - No combinational path from sig_in to sig_out.
// CONFIGURATION
//  - Macro SIG_FILTER_EDGE_EN.
//  - When defined: add output edge_out, registered, reset 0.
//    - It is high for exactly one clock on the edge where sig_out changes value.
//    - So edge_out == (sig_out_next != sig_out), registered alongside sig_out.
//  - When undefined: the edge_out port and its logic are absent; sig_out behaviour is identical.
// STRUCTURE
//  - Shared package sig_filter_pkg holds:
//    - SIG_FILTER_DEPTH_DEFAULT = 3
//    - DEPTH_MIN = 2 and DEPTH_MAX = 16
//    - a parameter-range check used by the top.
//  - One sub-module, sig_filter_hist: the DEPTH-bit shift register with synchronous active-low clear.
//    - It outputs all_ones and all_zeros flags.
//  - The top holds the sig_out hold/set/clear register and the optional edge_out register.
// TESTING  (DEPTH=3 unless noted)
//  - Reset: drive reset=0 for 1 edge with sig_in=1 -> sig_out=0 (and edge_out=0) after that edge.
//  - Steady high: release reset, sig_in=1 from edge 1 -> sig_out 0 through edge 3, 1 after edge 4.
//    - edge_out=1 only after edge 4.
//  - Glitch reject: with sig_out=1, sig_in=0 for 2 clocks then 1 -> sig_out stays 1.
//    - A 3-clock 0 run drops sig_out to 0 on the 4th edge.
//  - Hold: serial pattern 16'b0001_1101_0111_1101 sent MSB-first, one bit per clock, repeated.
//    - sig_out changes only after runs of >=3 identical bits, and holds across 1- or 2-bit runs.
//  - Reset mid-run: sig_in=1 for 2 clocks, reset=0 one edge, then sig_in=1 again.
//    - sig_out asserts 4 edges after reset release, not earlier.
//  - DEPTH=5 instance: a 4-clock high pulse is rejected; a 5-clock high pulse asserts sig_out on the 6th edge.

Source files
------------

// File: rtl/sig_filter_pkg.sv
// Shared constants and the DEPTH legality check for the sig_filter block.
// Latency and backpressure: not applicable (no logic).
package sig_filter_pkg;

    localparam int SIG_FILTER_DEPTH_DEFAULT = 3;
    localparam int DEPTH_MIN                = 2;
    localparam int DEPTH_MAX                = 16;

    function automatic bit depth_in_range(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/sig_filter_hist.sv
// DEPTH-bit sample history with synchronous active-low clear, flags all-ones / all-zeros.
// Latency: flags reflect samples up to the previous edge; no backpressure.
module sig_filter_hist
    import sig_filter_pkg::*;
#(
    parameter int DEPTH = SIG_FILTER_DEPTH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic all_ones,
    output logic all_zeros
);

    logic [DEPTH-1:0] hist_q;
    logic [DEPTH-1:0] hist_d;

    // Newest sample enters at bit 0.
    always_comb begin
        hist_d = {hist_q[DEPTH-2:0], sig_in};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign all_ones  = &hist_q;
    assign all_zeros = ~|hist_q;

endmodule

// File: rtl/sig_filter.sv
// Debouncer: sig_out follows sig_in only after DEPTH identical samples (DEPTH+1 edges); no backpressure.
// Optional registered one-cycle edge_out pulse when SIG_FILTER_EDGE_EN is defined.
module sig_filter
    import sig_filter_pkg::*;
#(
    parameter int DEPTH = SIG_FILTER_DEPTH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic sig_out
`ifdef SIG_FILTER_EDGE_EN
    ,
    output logic edge_out
`endif
);

    generate
        if (!depth_in_range(DEPTH)) begin : g_depth_check
            $error("sig_filter: DEPTH must be within DEPTH_MIN..DEPTH_MAX");
        end
    endgenerate

    logic all_ones;
    logic all_zeros;
    logic sig_out_q;
    logic sig_out_d;

    sig_filter_hist #(
        .DEPTH (DEPTH)
    ) u_hist (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .all_ones  (all_ones),
        .all_zeros (all_zeros)
    );

    // Set on a uniform-high history, clear on uniform-low, otherwise hold.
    always_comb begin
        sig_out_d = sig_out_q;
        if (all_ones) begin
            sig_out_d = 1'b1;
        end else if (all_zeros) begin
            sig_out_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sig_out_q <= 1'b0;
        end else begin
            sig_out_q <= sig_out_d;
        end
    end

    assign sig_out = sig_out_q;

`ifdef SIG_FILTER_EDGE_EN
    logic edge_out_q;
    logic edge_out_d;

    always_comb begin
        edge_out_d = (sig_out_d != sig_out_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            edge_out_q <= 1'b0;
        end else begin
            edge_out_q <= edge_out_d;
        end
    end

    assign edge_out = edge_out_q;
`endif

endmodule

// File: tb/tb_sig_filter.sv
// Directed bench for sig_filter: DEPTH=3 table plus hand-written sequences, and a DEPTH=5 instance.
module tb_sig_filter;

    logic clock;
    logic rst3, in3, out3;
    logic rst5, in5, out5;
`ifdef SIG_FILTER_EDGE_EN
    logic edge3, edge5;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sig_filter #(.DEPTH(3)) dut3 (
        .clock    (clock),
        .reset    (rst3),
        .sig_in   (in3),
        .sig_out  (out3)
`ifdef SIG_FILTER_EDGE_EN
        ,
        .edge_out (edge3)
`endif
    );

    sig_filter #(.DEPTH(5)) dut5 (
        .clock    (clock),
        .reset    (rst5),
        .sig_in   (in5),
        .sig_out  (out5)
`ifdef SIG_FILTER_EDGE_EN
        ,
        .edge_out (edge5)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic rst;
        logic in;
        logic exp_out;
        logic exp_edge;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick3(input logic r, input logic s);
        rst3 = r;
        in3  = s;
        @(posedge clock);
        #1;
    endtask

    task automatic tick5(input logic r, input logic s);
        rst5 = r;
        in5  = s;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] exp_rep1;
        logic [15:0] exp_rep2;

        rst3 = 1'b0; in3 = 1'b0;
        rst5 = 1'b0; in5 = 1'b0;

        // {reset, sig_in, expected sig_out, expected edge_out} after each edge
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0}; // reset with sig_in high
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1}; // asserts on edge 4
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0}; // 2-clock low glitch
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0}; // 3-clock low run
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1}; // drops on 4th edge
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            tick3(vecs[i].rst, vecs[i].in);
            check($sformatf("vec%0d sig_out", i), out3, vecs[i].exp_out);
`ifdef SIG_FILTER_EDGE_EN
            check($sformatf("vec%0d edge_out", i), edge3, vecs[i].exp_edge);
`endif
        end

        // Serial pattern MSB-first, twice; history starts all-0 with sig_out 0.
        pat      = 16'b0001_1101_0111_1101;
        exp_rep1 = 16'b0000_0011_1111_1111;
        exp_rep2 = 16'b1110_0011_1111_1111;
        for (int r = 0; r < 2; r++) begin
            for (int b = 15; b >= 0; b--) begin
                tick3(1'b1, pat[b]);
                check($sformatf("pattern rep%0d bit%0d", r, b), out3,
                      (r == 0) ? exp_rep1[b] : exp_rep2[b]);
            end
        end

        // Reset mid-run discards the partial history.
        tick3(1'b0, 1'b0);
        check("midrun pre-reset", out3, 1'b0);
        tick3(1'b1, 1'b1);
        tick3(1'b1, 1'b1);
        check("midrun partial", out3, 1'b0);
        tick3(1'b0, 1'b1);
        check("midrun reset", out3, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            tick3(1'b1, 1'b1);
            check($sformatf("midrun release edge%0d", e), out3, (e == 4) ? 1'b1 : 1'b0);
        end

        // DEPTH=5: 4-clock pulse rejected, 5-clock pulse asserts on 6th edge.
        tick5(1'b0, 1'b1);
        check("d5 reset", out5, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            tick5(1'b1, 1'b1);
            check($sformatf("d5 short pulse edge%0d", e), out5, 1'b0);
        end
        for (int e = 1; e <= 6; e++) begin
            tick5(1'b1, 1'b0);
            check($sformatf("d5 after short pulse edge%0d", e), out5, 1'b0);
        end
        for (int e = 1; e <= 6; e++) begin
            tick5(1'b1, 1'b1);
            check($sformatf("d5 long pulse edge%0d", e), out5, (e == 6) ? 1'b1 : 1'b0);
`ifdef SIG_FILTER_EDGE_EN
            check($sformatf("d5 long pulse edge_out%0d", e), edge5, (e == 6) ? 1'b1 : 1'b0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
